mux4_rr_sched: RTL

- Upstream control stage for the 4:1 data-select mux (inputs i0..i3, selects s1/s0).
- Arbitrates four request lines round-robin and drives s1/s0 so the winning channel is routed through the mux.
- Presents a valid/ready handshake to the downstream consumer of the mux output.
- Returns a one-cycle grant to the channel whose data was accepted.

---
 rtl/mux4_rr_sched.sv | 90 +++++++++
 1 files changed

// File: rtl/mux4_rr_sched.sv
// Round-robin control stage for a 4:1 data mux: picks a requesting channel,
// drives the mux selects and presents the routed item over valid/ready.
module mux4_rr_sched #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  output logic          s1,
  output logic          s0,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    gnt,
  output logic [CW-1:0] xfer_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [1:0]      sel, sel_n;
  logic [CW-1:0]   cnt_n;
  logic [3:0]      masked;
  logic            hs;

  // First set bit of r scanning from p upwards, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign out_valid = (state == ISSUE);
  assign hs        = out_valid & out_ready;
  assign s1        = sel[1];
  assign s0        = sel[0];
  assign gnt       = hs ? (4'b0001 << sel) : 4'b0000;
  assign masked    = req & ~(4'b0001 << sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      xfer_cnt <= cnt_n;
    end
  end

  // The served channel is masked only for the decision made on its handshake.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    cnt_n   = xfer_cnt;
    unique case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_n   = pick(req, ptr);
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          ptr_n = sel + 2'd1;
          cnt_n = xfer_cnt + CW'(1);
          if (masked != 4'b0000) begin
            sel_n = pick(masked, sel + 2'd1);
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
